// File: rtl/rd_scoreboard.sv
// Read-stage resource scoreboard: an in-order queue of outstanding writer masks
// with per-resource in-flight counters feeding a registered busy vector.

module rd_sb_res_cnt #(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic inc,
  input  logic dec,
  output logic busy
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    if (flush) cnt_d = '0;
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
endmodule

module rd_scoreboard #(
  parameter int RES_W = 11,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [RES_W-1:0] alloc_mask,
  output logic             alloc_ready,
  input  logic             retire_valid,
  input  logic [RES_W-1:0] query_mask,
  output logic             query_busy,
  output logic [RES_W-1:0] busy_vec,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             err_overflow,
  output logic             err_underflow
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic             push;
    logic             pop;
    logic [RES_W-1:0] inc;
    logic [RES_W-1:0] dec;
  } sb_op_t;

  logic [DEPTH-1:0][RES_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]            occ_q, occ_d;
  logic                        ovf_q, ovf_d, und_q, und_d;
  sb_op_t                      op;

  assign full  = (occ_q == CNT_W'(DEPTH));
  assign empty = (occ_q == '0);

  // Pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign alloc_ready = ~flush & (~full | (retire_valid & ~empty));

  always_comb begin
    op.push = alloc_valid & alloc_ready;
    op.pop  = retire_valid & ~empty & ~flush;
    op.inc  = {RES_W{op.push}} & alloc_mask;
    op.dec  = {RES_W{op.pop}} & mem_q[rd_q];
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    ovf_d = ovf_q | (alloc_valid & ~alloc_ready & ~flush);
    und_d = und_q | (retire_valid & empty & ~flush);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      if (op.push) begin
        mem_d[wr_q] = alloc_mask;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (op.pop) rd_d = rd_q + PTR_W'(1);
      occ_d = occ_q + CNT_W'(op.push) - CNT_W'(op.pop);
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      und_q <= und_d;
    end
  end

  for (genvar i = 0; i < RES_W; i++) begin : g_res
    rd_sb_res_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .inc   (op.inc[i]),
      .dec   (op.dec[i]),
      .busy  (busy_vec[i])
    );
  end

  assign query_busy    = |(query_mask & busy_vec);
  assign occupancy     = occ_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = und_q;
endmodule

// File: doc/rd_scoreboard.md
# rd_scoreboard

Parametrised read-stage resource scoreboard. It generalises the single-slot execute/write mutex tracking into an in-order queue of up to DEPTH outstanding writer masks. Per-resource counters let several in-flight instructions target the same resource. It sits between read and execute: read allocates an instruction's mutex mask on issue, write-back retires the oldest mask, and read-stage stall logic queries the registered busy vector.

## Interface
Parameters:
- RES_W, 11, width of a resource mask (bit 10 active, 9 memory, 8 eflags, 7..0 edi,esi,ebp,esp,ebx,edx,ecx,eax).
- DEPTH, 4, maximum outstanding entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of occupancy and per-resource counters.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, pipeline flush; discards all entries.
- alloc_valid, in, 1, push alloc_mask as youngest entry.
- alloc_mask, in, RES_W, resources written by the issuing instruction.
- alloc_ready, out, 1, push accepted this cycle.
- retire_valid, in, 1, pop oldest entry.
- query_mask, in, RES_W, resources the read stage wants to read.
- query_busy, out, 1, |(query_mask & busy_vec).
- busy_vec, out, RES_W, bit i set when res_cnt[i] ≠ 0 (registered).
- occupancy, out, CNT_W, number of valid entries.
- full, out, 1, occupancy == DEPTH.
- empty, out, 1, occupancy == 0.
- err_overflow, out, 1, sticky: alloc_valid while alloc_ready low.
- err_underflow, out, 1, sticky: retire_valid while empty.

## Operation
- Storage: DEPTH×RES_W mask RAM, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, occupancy counter, RES_W counters res_cnt[i] of CNT_W bits.
- alloc_ready = ~full | (retire_valid & ~empty); combinational, and low while flush is high.
- push = alloc_valid & alloc_ready. Write mask[wr_ptr] and increment wr_ptr.
- pop = retire_valid & ~empty. Read mask[rd_ptr], increment rd_ptr, and decrement res_cnt[i] for each set bit of the popped mask.
- Per resource i: res_cnt[i] += (push & alloc_mask[i]) − (pop & mask[rd_ptr][i]). Simultaneous push and pop on the same bit leaves the count unchanged.
- occupancy += push − pop.
- Push and pop on the same cycle when full is legal. The popped entry is read before it is overwritten (pointers are equal only when full or empty).
- Push and pop on the same cycle when empty: push only. The pop is ignored and err_underflow is set.
- flush takes priority over everything. Next edge: pointers, occupancy and all res_cnt = 0. Sticky errors are not cleared by flush. A push or pop in the flush cycle is discarded and raises no error.
- Errors clear only on reset. No other side effect: the offending request is dropped.
- An all-zero alloc_mask is a valid entry. It occupies a slot and affects no counter.
- Reset: ptrs, occupancy, res_cnt, busy_vec, err_* = 0. Outputs: empty = 1, full = 0, alloc_ready = 1, query_busy = 0. Mask RAM contents are don't-care.

## Timing
- All state updates on posedge clk; reset is asynchronous on negedge rst_n with synchronous deassert expected upstream.
- Push at edge N sets busy_vec bits from cycle N+1 (1-cycle latency). There is no bypass: same-cycle alloc_mask never affects query_busy.
- Pop at edge N clears busy_vec bit i in cycle N+1 only if res_cnt[i] reaches 0. There is no early release: query_busy stays high in the retire cycle.
- query_busy is purely combinational from query_mask and registered busy_vec.
- full, empty, occupancy and busy_vec are registered-derived and glitch-free.
- alloc_ready depends combinationally on retire_valid. The write-back stage must not depend on alloc_ready.
- Reset asserted mid-operation: all state is cleared immediately, without waiting for clk.

## Test plan
- Reset, then idle: empty=1, full=0, alloc_ready=1, busy_vec=0, occupancy=0, both errors 0.
- Alloc 0x401 (active+eax), then 0x401 again, then retire, then retire. busy_vec[0] is 1 after the first edge, stays 1 after the first retire (cnt 2→1), and is 0 after the second retire. occupancy goes 1,2,1,0.
- Fill DEPTH=4 with 0x410, 0x420, 0x440, 0x480: full=1, alloc_ready=0. A fifth alloc alone gives err_overflow=1 and occupancy stays 4. Alloc 0x401 together with retire: accepted, busy_vec=0x4E1, occupancy=4.
- Retire when empty gives err_underflow=1 with occupancy 0. Alloc+retire on empty: occupancy=1, busy_vec=alloc_mask.
- Push 3 entries, then assert flush together with alloc 0x408. Next cycle: occupancy=0, busy_vec=0, no overflow flag. Previously set error flags persist.
- Wrap-around: 10 cycles of alloc+retire with rotating masks. busy_vec always equals the single outstanding mask. query_mask=0x004 gives query_busy=1 exactly when the outstanding mask has bit 2 set.
